uart_mmio_tx: RTL and testbench

- Memory-mapped UART transmitter that consumes store traffic from both memory-stage slots (M1, M2) of the dual-issue RV32I core.
- A store of any size to the UART data address pushes its low byte into a FIFO.
- A baud-timed FSM serialises bytes 8N1, LSB first, onto the top-level uart_tx line.
- Sits beside data_ram, downstream of the M stages; asserts stall to hold the pipeline when the FIFO cannot accept.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_fifo.sv | 49 ++++
 rtl/uart_mmio_tx.sv | 119 +++++++++++
 tb/tb_uart_mmio_tx.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Store-size encoding carried by mem_store1/mem_store2, also used by data_ram.
  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_B    = 2'b01;
  localparam logic [1:0] ST_H    = 2'b10;
  localparam logic [1:0] ST_W    = 2'b11;

  localparam logic [31:0] UART_ADDR_DEFAULT = 32'h0000_F000;

endpackage

// File: rtl/uart_fifo.sv
// Dual-write, single-read circular byte FIFO; wd1 is the older entry when both write.
module uart_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we1,
  input  logic [7:0]               wd1,
  input  logic                     we2,
  input  logic [7:0]               wd2,
  input  logic                     re,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic [7:0]               rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_p1;
  logic [PW-1:0] wr_idx2;

  // Pointers wrap naturally because DEPTH is a power of two.
  assign wr_ptr_p1 = wr_ptr + 1'b1;
  assign wr_idx2   = we1 ? wr_ptr_p1 : wr_ptr;
  assign empty     = (count == '0);
  assign rdata     = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'({1'b0, we1} + {1'b0, we2});
      if (re) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(we1) + CW'(we2) - CW'(re);
    end
  end

  always_ff @(posedge clk) begin
    if (we1) mem[wr_ptr]  <= wd1;
    if (we2) mem[wr_idx2] <= wd2;
  end

endmodule

// File: rtl/uart_mmio_tx.sv
// UART transmitter fed by stores from both M-stage slots; stalls the pipe when the FIFO cannot take them.
module uart_mmio_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] UART_ADDR    = UART_ADDR_DEFAULT,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic [1:0]  mem_store1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  input  logic [1:0]  mem_store2,
  input  logic [31:0] addr2,
  input  logic [31:0] wdata2,
  output logic        stall,
  output logic        tx_busy,
  output logic        uart_tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [CW:0]   DEPTH_V  = (CW + 1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  logic          req1, req2;
  logic [CW-1:0] count;
  logic [CW:0]   demand;
  logic          fifo_empty;
  logic [7:0]    fifo_rdata;
  logic          pop;
  logic          unused_hi;

  tx_state_t     state, state_next;
  logic [BW-1:0] baud_cnt, baud_next;
  logic [2:0]    bit_idx, bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic          tx_next;

  // Handshake: reqN is the valid of each slot and !stall is the shared ready;
  // both slots transfer together or neither does, and a stalled pair is re-presented.
  assign req1   = (mem_store1 != ST_NONE) && (addr1 == UART_ADDR);
  assign req2   = (mem_store2 != ST_NONE) && (addr2 == UART_ADDR);
  assign demand = {1'b0, count} + {{CW{1'b0}}, req1} + {{CW{1'b0}}, req2};
  assign stall  = (demand > DEPTH_V);

  assign tx_busy   = (count != '0) || (state != IDLE);
  assign unused_hi = ^{wdata1[31:8], wdata2[31:8]};

  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (CLK),
    .rst_n (NRST),
    .we1   (req1 && !stall),
    .wd1   (wdata1[7:0]),
    .we2   (req2 && !stall),
    .wd2   (wdata2[7:0]),
    .re    (pop),
    .count (count),
    .empty (fifo_empty),
    .rdata (fifo_rdata)
  );

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      uart_tx   <= 1'b1;
    end else begin
      state     <= state_next;
      baud_cnt  <= baud_next;
      bit_idx   <= bit_next;
      shift_reg <= shift_next;
      uart_tx   <= tx_next;
    end
  end

  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    shift_next = shift_reg;
    pop        = 1'b0;
    tx_next    = 1'b1;
    if (state != IDLE) baud_next = baud_cnt - 1'b1;
    case (state)
      IDLE: if (!fifo_empty) begin
        pop        = 1'b1;
        shift_next = fifo_rdata;
        baud_next  = BAUD_MAX;
        state_next = START;
      end
      START: if (baud_cnt == '0) begin
        baud_next  = BAUD_MAX;
        bit_next   = 3'd0;
        state_next = DATA;
      end
      DATA: if (baud_cnt == '0) begin
        baud_next = BAUD_MAX;
        if (bit_idx == 3'd7) state_next = STOP;
        else                 bit_next   = bit_idx + 3'd1;
      end
      STOP: if (baud_cnt == '0) begin
        baud_next  = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // The line level is computed from the next state so uart_tx comes straight from a flop.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[bit_next];
      default: tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_mmio_tx.sv
// Directed bench for uart_mmio_tx with a serial-line receiver scoreboard.
module tb_uart_mmio_tx;
  import uart_pkg::*;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam logic [31:0] UADDR = 32'h0000_F000;

  logic        CLK = 1'b0;
  logic        NRST = 1'b0;
  logic [1:0]  mem_store1 = '0;
  logic [31:0] addr1 = '0;
  logic [31:0] wdata1 = '0;
  logic [1:0]  mem_store2 = '0;
  logic [31:0] addr2 = '0;
  logic [31:0] wdata2 = '0;
  logic        stall, tx_busy, uart_tx;

  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         frames = 0;
  bit         rx_en = 1'b0;
  logic [7:0] exp_q[$];
  int         start_q[$];

  uart_mmio_tx #(.UART_ADDR(UADDR), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .NRST       (NRST),
    .mem_store1 (mem_store1),
    .addr1      (addr1),
    .wdata1     (wdata1),
    .mem_store2 (mem_store2),
    .addr2      (addr2),
    .wdata2     (wdata2),
    .stall      (stall),
    .tx_busy    (tx_busy),
    .uart_tx    (uart_tx)
  );

  // clock / reset
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drives a store pair at a negedge, holds it while stalled, clears it one cycle after acceptance.
  task automatic present(input logic [1:0] s1, input logic [31:0] a1, input logic [31:0] d1,
                         input logic [1:0] s2, input logic [31:0] a2, input logic [31:0] d2,
                         output logic first_stall, output int stalls);
    @(negedge CLK);
    mem_store1 = s1; addr1 = a1; wdata1 = d1;
    mem_store2 = s2; addr2 = a2; wdata2 = d2;
    #1;
    first_stall = stall;
    stalls = 0;
    while (stall && stalls < 500) begin
      @(negedge CLK);
      #1;
      stalls++;
    end
    if (stall) check("stall_timeout", {31'd0, stall}, 32'd0);
    @(negedge CLK);
    mem_store1 = ST_NONE; addr1 = '0; wdata1 = '0;
    mem_store2 = ST_NONE; addr2 = '0; wdata2 = '0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge CLK);
    while (tx_busy && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    check("idle_timeout", {31'd0, tx_busy}, 32'd0);
  endtask

  // Receiver scoreboard: samples mid-bit and compares each frame against exp_q.
  initial begin
    logic [7:0] b;
    logic [7:0] e;
    forever begin
      @(negedge CLK);
      if (rx_en && uart_tx === 1'b0) begin
        start_q.push_back(cyc);
        repeat (CPB / 2) @(negedge CLK);
        check("rx_start", {31'd0, uart_tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge CLK);
          b[i] = uart_tx;
        end
        repeat (CPB) @(negedge CLK);
        check("rx_stop", {31'd0, uart_tx}, 32'd1);
        frames++;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else                  e = 'x;
        check("rx_byte", {24'd0, b}, {24'd0, e});
      end
    end
  end

  initial begin
    logic       fs;
    int         st;
    int         busy_n;
    int         f0;
    logic [9:0] seq;

    // reset and idle line
    repeat (3) @(negedge CLK);
    check("rst_tx", {31'd0, uart_tx}, 32'd1);
    check("rst_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    NRST = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      check("idle_line", {29'd0, uart_tx, stall, tx_busy}, 32'h4);
    end
    rx_en = 1'b1;

    // single sb 0x41, bit-exact line check
    exp_q.push_back(8'h41);
    present(ST_B, UADDR, 32'h0000_0041, ST_NONE, 32'd0, 32'd0, fs, st);
    check("sb_stall", {31'd0, fs}, 32'd0);
    check("pop_cycle_tx", {31'd0, uart_tx}, 32'd1);
    busy_n = tx_busy ? 1 : 0;
    seq = 10'b1_0100_0001_0;
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < CPB; j++) begin
        @(negedge CLK);
        check("frame_bit", {31'd0, uart_tx}, {31'd0, seq[k]});
        busy_n += tx_busy ? 1 : 0;
      end
    end
    @(negedge CLK);
    check("busy_drop", {31'd0, tx_busy}, 32'd0);
    check("busy_len", busy_n, 32'd41);
    wait_idle();
    repeat (5) @(negedge CLK);

    // dual store same cycle: 0x55 (slot 1) then 0x66 (slot 2)
    start_q.delete();
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h66);
    present(ST_W, UADDR, 32'h1234_5655, ST_B, UADDR, 32'h0000_0066, fs, st);
    check("dual_stall", {31'd0, fs}, 32'd0);
    wait_idle();
    repeat (5) @(negedge CLK);
    check("dual_frames", start_q.size(), 32'd2);
    check("frame_pitch", (start_q.size() >= 2) ? start_q[1] - start_q[0] : 0, 32'd41);

    // stores that must be ignored
    present(ST_W, UADDR + 32'd4, 32'h0000_00AB, ST_W, 32'd0, 32'h0000_00CD, fs, st);
    check("other_addr_stall", {31'd0, fs}, 32'd0);
    present(ST_NONE, UADDR, 32'h0000_0077, ST_NONE, UADDR, 32'h0000_0078, fs, st);
    check("no_size_stall", {31'd0, fs}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      check("ignored_line", {30'd0, uart_tx, tx_busy}, 32'h2);
    end

    // fill to 3 queued, then a dual store must stall until one more pop
    f0 = frames;
    exp_q.push_back(8'hA1); exp_q.push_back(8'hB2); exp_q.push_back(8'hC3);
    exp_q.push_back(8'hD4); exp_q.push_back(8'hE5); exp_q.push_back(8'hF6);
    present(ST_B, UADDR, 32'h0000_00A1, ST_B, UADDR, 32'h0000_00B2, fs, st);
    check("fill1_stall", {31'd0, fs}, 32'd0);
    present(ST_H, UADDR, 32'h0000_BEC3, ST_W, UADDR, 32'hDEAD_00D4, fs, st);
    check("fill2_stall", {31'd0, fs}, 32'd0);
    present(ST_B, UADDR, 32'h0000_00E5, ST_B, UADDR, 32'h0000_00F6, fs, st);
    check("full_stall", {31'd0, fs}, 32'd1);
    check("stall_cycles", st, 32'd39);
    wait_idle();
    repeat (5) @(negedge CLK);
    check("fill_frames", frames - f0, 32'd6);
    check("exp_q_drained", exp_q.size(), 32'd0);

    // reset during DATA bit 3 of 0xA5 with 0x3C still queued
    rx_en = 1'b0;
    present(ST_B, UADDR, 32'h0000_00A5, ST_B, UADDR, 32'h0000_003C, fs, st);
    repeat (18) @(negedge CLK);
    check("pre_rst_bit3", {31'd0, uart_tx}, 32'd0);
    NRST = 1'b0;
    #1;
    check("midrst_tx", {31'd0, uart_tx}, 32'd1);
    check("midrst_busy", {31'd0, tx_busy}, 32'd0);
    check("midrst_stall", {31'd0, stall}, 32'd0);
    repeat (2) @(negedge CLK);
    NRST = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      check("post_rst_line", {29'd0, uart_tx, tx_busy, stall}, 32'h4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
